mem_access_unit: RTL
====================

# mem_access_unit

Parametrised load/store unit for the multicycle RV32I core and its 64-bit successor. It replaces the MAR/MDR registers, the store-data shift path and the fixed lb/lbu/lh/lhu/lw extractors with one FSM-driven block. The block adds a request/response handshake toward control, variable-latency memory handling via `mem_resp`, byte enables, and optional splitting of misaligned accesses into two bus beats. It sits between the datapath/control and the memory port.

## Interface
- `XLEN`, default 32: register and data width; 32 or 64.
- `BUS_W`, default 32: memory bus width in bits; power of two, ≥ `XLEN`.
- `ALLOW_MISALIGNED`, default 1:
  - 1: accesses that cross a bus word are split into two beats.
  - 0: such accesses are rejected with an error.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `req_valid` in 1: control presents an access.
- `req_ready` out 1: high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double (legal only when `XLEN` = 64).
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in XLEN: store data, right-justified.
- `rsp_valid` out 1: one-cycle pulse when the access completes.
- `rsp_rdata` out XLEN: extended load data; 0 for stores and for errors.
- `rsp_err` out 1: misaligned access rejected or illegal size; qualified by `rsp_valid`.
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_address` out 32: bus-aligned address (low log2(`BUS_W`/8) bits are 0).
- `mem_wdata` out BUS_W: lane-positioned store data.
- `mem_byte_enable` out BUS_W/8: active store lanes; all ones on reads.
- `mem_rdata` in BUS_W: read data, valid when `mem_resp` is high.
- `mem_resp` in 1: memory completes the current beat.

## Operation
- **States and transitions:** IDLE → BEAT0 → (BEAT1) → DONE → IDLE.
- **Accept:** on `req_valid && req_ready`, all request fields are latched.
  - `off` = `addr mod (BUS_W/8)`; `nbytes` = 2^size.
  - A split is needed when `off + nbytes > BUS_W/8`.
- **Illegal size or rejected split:** if size is illegal, or a split is needed and `ALLOW_MISALIGNED` = 0, the FSM goes IDLE → DONE with `rsp_err` = 1 and no memory strobe.
- **BEAT0:**
  - Strobe asserted at the bus-aligned address.
  - Store: `mem_wdata` = wdata << 8·off; `mem_byte_enable` = ((1<<nbytes)−1) << off, truncated to the bus.
  - Address, data, enables and strobe are held stable until `mem_resp`.
  - On `mem_resp`, read lanes are captured into the assembly register.
- **BEAT1 (split only):**
  - Address = BEAT0 address + BUS_W/8, modulo 2^32 (wraps).
  - Carries the overflow bytes in lanes 0 upward.
  - Read bytes are appended above the BEAT0 bytes.
- **DONE:**
  - `rsp_valid` = 1 for exactly one cycle.
  - `rsp_rdata` = assembled bytes, sign- or zero-extended from 8·nbytes to XLEN.
- **Strobe release:** strobes deassert in the cycle after `mem_resp`; `mem_resp` is ignored outside the beat states.
- **Reset:** all registers clear and the FSM returns to IDLE.
  - An outstanding beat is abandoned and no `rsp_valid` is issued for it.
  - Reset values: `req_ready` = 1; every other output = 0.

## Timing
- **Aligned access:** accepted at edge T; strobe high from T+1; `mem_resp` in cycle T+1+k (k ≥ 0 wait cycles); `rsp_valid` at T+2+k.
- **Split access:** adds 1 + k2 cycles, where k2 is the BEAT1 wait count.
- **Error path:** `rsp_valid` in the cycle after accept.
- **Throughput:** the next request can be accepted in the cycle after DONE; no overlap between accesses.
- **Output timing:** all outputs are registered or decoded from state only; no combinational path from `mem_rdata` or `mem_resp` to `mem_*` outputs.

## Structure
- **Shared package `rv32i_types`:**
  - `mem_size_t` enum (`size_b`, `size_h`, `size_w`, `size_d`).
  - `mau_state_t` enum (`mau_idle`, `mau_beat0`, `mau_beat1`, `mau_done`).
- **Sub-module `mem_lane_shift`** (combinational, parametrised by `BUS_W`):
  - Store lane placement and byte-enable generation for a given offset and beat.
  - Instantiated once per direction.

## Test plan
- **Aligned LW:** LW `0x100`, `mem_rdata` = `0xDEADBEEF`, 2 wait cycles → `mem_address` = `0x100`; `rsp_rdata` = `0xDEADBEEF` at accept+4.
- **Byte loads:** `mem_rdata` = `0x80000000`.
  - LB `0x103` → `0xFFFFFF80`.
  - LBU `0x103` → `0x00000080`.
- **Half store:** SH `0x102`, wdata `0x1234ABCD` → `mem_wdata` = `0xABCD0000`, `mem_byte_enable` = `1100`, `mem_write` held until `mem_resp`.
- **Split load:** LW `0x0FE`.
  - Beat 0 at `0x0FC` returns `0xAABBCCDD`; beat 1 at `0x100` returns `0x11223344`.
  - Result `0x3344AABB`, single `rsp_valid`.
  - With `ALLOW_MISALIGNED` = 0 → no strobe; `rsp_err` = 1 and `rsp_rdata` = 0 at accept+1.
- **Split store with wrap:** SW `0xFFFFFFFE`, wdata `0x11223344`.
  - Beat 0: `0xFFFFFFFC`, enables `1100`, data `0x33440000`.
  - Beat 1: `0x00000000`, enables `0011`, data `0x00001122`.
- **Reset mid-access:** `rst` pulsed during BEAT1 → `mem_read` drops immediately and `req_ready` = 1, with no `rsp_valid`. A following aligned LW completes normally.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared types for the RV32I/RV64I memory path: access sizes, load/store FSM
// states and a helper that turns an access size into a byte count.
package rv32i_types;

    typedef enum logic [1:0] {
        size_b = 2'd0,
        size_h = 2'd1,
        size_w = 2'd2,
        size_d = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        mau_idle  = 2'd0,
        mau_beat0 = 2'd1,
        mau_beat1 = 2'd2,
        mau_done  = 2'd3
    } mau_state_t;

    function automatic logic [3:0] size_bytes(input mem_size_t s);
        return 4'd1 << s;
    endfunction

endpackage

// File: rtl/mem_lane_shift.sv
// Byte-lane placement between a right-justified value and the memory bus for
// either beat of a possibly split access; LOAD selects the direction.
module mem_lane_shift
    import rv32i_types::*;
#(
    parameter int BUS_W = 32,
    parameter bit LOAD  = 1'b0,
    localparam int NB   = BUS_W / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [OFFW-1:0]  off_i,
    input  mem_size_t        size_i,
    input  logic             beat1_i,
    input  logic [BUS_W-1:0] data_i,
    output logic [BUS_W-1:0] data_o,
    output logic [NB-1:0]    lane_en_o
);

    int offInt;
    int nbInt;
    int shInt;

    // Beat 1 always starts at lane 0 of the next bus word, so the bytes it
    // carries begin at index NB-off of the right-justified value.
    always_comb begin
        data_o    = '0;
        lane_en_o = '0;
        offInt    = int'(off_i);
        nbInt     = int'(size_bytes(size_i));
        shInt     = NB - offInt;
        for (int i = 0; i < NB; i++) begin
            if (LOAD) begin
                if (!beat1_i) begin
                    if (i + offInt < NB) begin
                        data_o[8*i +: 8] = data_i[8*(i+offInt) +: 8];
                    end
                    lane_en_o[i] = (i < nbInt);
                end else begin
                    if (i >= shInt) begin
                        data_o[8*i +: 8] = data_i[8*(i-shInt) +: 8];
                    end
                    lane_en_o[i] = (i >= shInt) && (i < nbInt);
                end
            end else begin
                if (!beat1_i) begin
                    if ((i >= offInt) && (i - offInt < nbInt)) begin
                        data_o[8*i +: 8] = data_i[8*(i-offInt) +: 8];
                        lane_en_o[i]     = 1'b1;
                    end
                end else begin
                    if ((i + shInt < nbInt) && (i + shInt < NB)) begin
                        data_o[8*i +: 8] = data_i[8*(i+shInt) +: 8];
                        lane_en_o[i]     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: latches one request, drives one or two bus beats with
// lane-positioned data, and returns extended load data with a one-cycle pulse.
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int XLEN             = 32,
    parameter int BUS_W            = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [31:0]        req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output logic               rsp_valid,
    output logic [XLEN-1:0]    rsp_rdata,
    output logic               rsp_err,
    output logic               mem_read,
    output logic               mem_write,
    output logic [31:0]        mem_address,
    output logic [BUS_W-1:0]   mem_wdata,
    output logic [BUS_W/8-1:0] mem_byte_enable,
    input  logic [BUS_W-1:0]   mem_rdata,
    input  logic               mem_resp
);

    localparam int NB   = BUS_W / 8;
    localparam int OFFW = $clog2(NB);

    mau_state_t        state_q, state_d;
    logic              write_q, write_d;
    mem_size_t         sz_q, sz_d;
    logic              sgn_q, sgn_d;
    logic [31:0]       addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [BUS_W-1:0]  asm_q, asm_d;
    logic              err_q, err_d;

    logic [OFFW-1:0]   reqOff;
    logic [3:0]        reqBytes;
    logic              reqSplit;
    logic              reqIllegal;
    logic [OFFW-1:0]   curOff;
    logic [3:0]        curBytes;
    logic              curSplit;
    logic              inBeat;
    logic              isBeat1;
    logic [31:0]       alignedAddr;
    logic [BUS_W-1:0]  wdataBus;
    logic [BUS_W-1:0]  stData;
    logic [NB-1:0]     stEn;
    logic [BUS_W-1:0]  ldData;
    logic [NB-1:0]     ldEn;
    logic [BUS_W-1:0]  mergedAsm;
    logic [XLEN-1:0]   extData;
    logic              signBit;

    always_comb begin
        reqOff     = req_addr[OFFW-1:0];
        reqBytes   = size_bytes(mem_size_t'(req_size));
        reqSplit   = (int'(reqOff) + int'(reqBytes)) > NB;
        reqIllegal = (req_size == size_d) && (XLEN != 64);
        curOff     = addr_q[OFFW-1:0];
        curBytes   = size_bytes(sz_q);
        curSplit   = (int'(curOff) + int'(curBytes)) > NB;
        inBeat     = (state_q == mau_beat0) || (state_q == mau_beat1);
        isBeat1    = (state_q == mau_beat1);
        alignedAddr = {addr_q[31:OFFW], {OFFW{1'b0}}};
        wdataBus   = '0;
        wdataBus[XLEN-1:0] = wdata_q;
    end

    mem_lane_shift #(
        .BUS_W (BUS_W),
        .LOAD  (1'b0)
    ) u_store_shift (
        .off_i     (curOff),
        .size_i    (sz_q),
        .beat1_i   (isBeat1),
        .data_i    (wdataBus),
        .data_o    (stData),
        .lane_en_o (stEn)
    );

    mem_lane_shift #(
        .BUS_W (BUS_W),
        .LOAD  (1'b1)
    ) u_load_shift (
        .off_i     (curOff),
        .size_i    (sz_q),
        .beat1_i   (isBeat1),
        .data_i    (mem_rdata),
        .data_o    (ldData),
        .lane_en_o (ldEn)
    );

    always_comb begin
        mergedAsm = asm_q;
        for (int i = 0; i < NB; i++) begin
            if (ldEn[i]) begin
                mergedAsm[8*i +: 8] = ldData[8*i +: 8];
            end
        end
    end

    // Sign source is the top byte actually assembled, not the top of the bus.
    always_comb begin
        extData = '0;
        signBit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == int'(curBytes) - 1) begin
                signBit = asm_q[8*i+7];
            end
        end
        for (int i = 0; i < XLEN/8; i++) begin
            if (i < int'(curBytes)) begin
                extData[8*i +: 8] = asm_q[8*i +: 8];
            end else begin
                extData[8*i +: 8] = {8{sgn_q & signBit}};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        sz_d    = sz_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        err_d   = err_q;
        unique case (state_q)
            mau_idle: begin
                if (req_valid) begin
                    write_d = req_write;
                    sz_d    = mem_size_t'(req_size);
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    asm_d   = '0;
                    err_d   = reqIllegal || (reqSplit && !ALLOW_MISALIGNED);
                    state_d = err_d ? mau_done : mau_beat0;
                end
            end
            mau_beat0: begin
                if (mem_resp) begin
                    if (!write_q) begin
                        asm_d = mergedAsm;
                    end
                    state_d = curSplit ? mau_beat1 : mau_done;
                end
            end
            mau_beat1: begin
                if (mem_resp) begin
                    if (!write_q) begin
                        asm_d = mergedAsm;
                    end
                    state_d = mau_done;
                end
            end
            mau_done: begin
                state_d = mau_idle;
            end
            default: begin
                state_d = mau_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= mau_idle;
            write_q <= 1'b0;
            sz_q    <= size_b;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            sz_q    <= sz_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs decode only from registered state, never from mem_resp.
    always_comb begin
        req_ready       = (state_q == mau_idle);
        mem_read        = inBeat && !write_q;
        mem_write       = inBeat && write_q;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        if (inBeat) begin
            mem_address = alignedAddr + (isBeat1 ? 32'(NB) : 32'd0);
        end
        if (mem_write) begin
            mem_wdata       = stData;
            mem_byte_enable = stEn;
        end else if (mem_read) begin
            mem_byte_enable = '1;
        end
        rsp_valid = (state_q == mau_done);
        rsp_err   = (state_q == mau_done) && err_q;
        rsp_rdata = '0;
        if ((state_q == mau_done) && !err_q && !write_q) begin
            rsp_rdata = extData;
        end
    end

endmodule
